vec_seq_ctrl: RTL and testbench
===============================

VEC_SEQ_CTRL -- requirements
Module: vec_seq_ctrl

Interface
REQ-001 Parameter LANES, 4, number of vector ALU lanes (power of two).
REQ-002 Parameter VLEN_MAX, 16, maximum elements per vector instruction (multiple of LANES).
REQ-003 One clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  asynchronous active-high reset.
REQ-006 issueValid  input  1  valid instruction in decode.
REQ-007 opcodeD  input  4  decode-stage opcode.
REQ-008 vecLen  input  5  element count of the instruction.
REQ-009 flushE  input  1  taken branch from condition logic (PCSrc).
REQ-010 memReady  input  1  memory accepts the current vector group.
REQ-011 stallF, stallD  output  1 each  hold fetch/decode registers.
REQ-012 laneEn  output  LANES  per-lane write enable for the current group.
REQ-013 groupIdx  output  clog2(VLEN_MAX/LANES)  current element group.
REQ-014 aluIssue  output  1  ALU group valid this cycle.
REQ-015 memReq  output  1  memory group request.
REQ-016 flagUpdate  output  1  zero-flag capture strobe.
REQ-017 busy  output  1  sequencing in progress.
REQ-018 done  output  1  one-cycle completion pulse.

Function
REQ-019 Opcode classes: 0000-0111 vector ALU (0111 = vector compare); 1010 vector load; 1011 vector store; all other opcodes scalar and never sequenced.
REQ-020 FSM states IDLE, ALU, MEM; an issue is accepted only in IDLE when issueValid=1, opcode vector-class, effVen!=0 and flushE=0.
REQ-021 effLen = min(vecLen, VLEN_MAX); effLen=0 is a no-op: no stall, no busy, no done.
REQ-022 On acceptance, opcode and effLen latch; next state ALU (ALU class) or MEM (load/store); groupIdx=0.
REQ-023 Groups = ceil(effLen/LANES); last group is groupIdx = Groups-1.
REQ-024 laneEn = all ones for non-last groups; for the last group, low (effLen mod LANES) bits, or all ones if mod is 0; laneEn=0 in IDLE.
REQ-025 ALU state: aluIssue=1 every cycle; groupIdx increments each cycle; after last group, next state IDLE.
REQ-026 MEM state: memReq=1; groupIdx advances only when memReady=1; after last group accepted, next state IDLE; memReady ignored outside MEM.
REQ-027 flagUpdate = aluIssue & lastGroup & latched opcode 0111.
REQ-028 stallF = stallD = (IDLE & accept) | (busy & ~(lastGroup & (ALU | memReady))); stall released in the final group cycle.
REQ-029 busy=1 in ALU and MEM.
REQ-030 done pulses (registered) in the cycle after the final group completes.
REQ-031 flushE=1 in ALU/MEM: next state IDLE, groupIdx cleared, no done; aluIssue/memReq remain asserted in the flush cycle itself but laneEn=0.
REQ-032 flushE and issueValid in the same IDLE cycle: issue ignored, no stall.
REQ-033 In IDLE, aluIssue, memReq, flagUpdate, busy are 0.

Reset
REQ-034 reset=1 forces IDLE, groupIdx=0, latched opcode/length=0 and all outputs 0 immediately, including mid-operation; no done follows.
REQ-035 First issue is accepted in the first clock edge after reset deasserts.

Structure
REQ-036 Package vec_pkg holds opcode constants, the opcode-class decode, state enum, LANES and VLEN_MAX defaults.
REQ-037 Sub-module lane_mask_gen computes laneEn from effLen, groupIdx and lastGroup.

Verification
REQ-038 ALU op 0000, vecLen=16 -> aluIssue 4 cycles, groupIdx 0..3, laneEn 1111 each, stall high 4 cycles, done pulse on cycle 5.
REQ-039 Compare 0111, vecLen=6 -> 2 groups, laneEn 1111 then 0011, flagUpdate only with group 1.
REQ-040 Load 1010, vecLen=8, memReady low 3 cycles then high -> groupIdx holds 0 for 3 cycles, 1 group per ready cycle, done after group 1.
REQ-041 ALU op vecLen=16, flushE at group 1 -> IDLE next cycle, laneEn=0 during flush cycle, no done.
REQ-042 vecLen=0 or 20 -> no-op respectively 4 groups (clamped); scalar opcode 1000 -> no stall.
REQ-043 reset asserted mid-MEM -> all outputs 0 asynchronously, new issue accepted after deassertion.

Source files
------------

// File: rtl/vec_pkg.sv
// vec_pkg: opcode constants, class decode, FSM states and default sizing for vec_seq_ctrl
package vec_pkg;
  localparam int LANES_DEF = 4;
  localparam int VLEN_MAX_DEF = 16;
  localparam logic [3:0] OP_CMP = 4'b0111;
  localparam logic [3:0] OP_LD = 4'b1010;
  localparam logic [3:0] OP_ST = 4'b1011;
  typedef enum logic [1:0] {IDLE, ALU, MEM} state_t;
  function automatic logic is_alu(input logic [3:0] op);
    return ~op[3];
  endfunction
  function automatic logic is_mem(input logic [3:0] op);
    return op == OP_LD || op == OP_ST;
  endfunction
endpackage

// File: rtl/lane_mask_gen.sv
// lane_mask_gen: per-lane enables, trimming the tail of the final element group
module lane_mask_gen import vec_pkg::*; #(
  parameter int LANES = LANES_DEF,
  parameter int GW = 2
) (
  input  logic [4:0]       eff_len,
  input  logic [GW-1:0]    group_idx,
  input  logic             last_group,
  output logic [LANES-1:0] lane_en
);
  always_comb
    for (int i = 0; i < LANES; i++)
      lane_en[i] = ~last_group | (int'(group_idx) * LANES + i < int'(eff_len));
endmodule

// File: rtl/vec_seq_ctrl.sv
// vec_seq_ctrl: sequences vector ALU and load/store instructions over LANES-wide element groups
module vec_seq_ctrl import vec_pkg::*; #(
  parameter int LANES = LANES_DEF,
  parameter int VLEN_MAX = VLEN_MAX_DEF
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               issueValid,
  input  logic [3:0]                         opcodeD,
  input  logic [4:0]                         vecLen,
  input  logic                               flushE,
  input  logic                               memReady,
  output logic                               stallF,
  output logic                               stallD,
  output logic [LANES-1:0]                   laneEn,
  output logic [$clog2(VLEN_MAX/LANES)-1:0]  groupIdx,
  output logic                               aluIssue,
  output logic                               memReq,
  output logic                               flagUpdate,
  output logic                               busy,
  output logic                               done
);
  localparam int GW = $clog2(VLEN_MAX / LANES);
  localparam int LW = $clog2(LANES);
  state_t state, state_n;
  logic [3:0] op_q, op_n;
  logic [4:0] len_q, len_n, eff_len;
  logic [GW-1:0] grp, grp_n;
  logic [LANES-1:0] mask;
  logic accept, last, advance, done_n;
  lane_mask_gen #(.LANES(LANES), .GW(GW)) u_mask (
    .eff_len(len_q), .group_idx(grp), .last_group(last), .lane_en(mask)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      op_q <= '0;
      len_q <= '0;
      grp <= '0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      op_q <= op_n;
      len_q <= len_n;
      grp <= grp_n;
      done <= done_n;
    end
  // accept is gated by reset so stalls drop the instant reset asserts
  always_comb begin
    eff_len = (int'(vecLen) > VLEN_MAX) ? 5'(VLEN_MAX) : vecLen;
    accept = ~reset & (state == IDLE) & issueValid & (is_alu(opcodeD) | is_mem(opcodeD))
           & (eff_len != 5'd0) & ~flushE;
    last = (state != IDLE) && (grp == GW'((len_q - 5'd1) >> LW));
    advance = (state == ALU) || (state == MEM && memReady);
    aluIssue = state == ALU;
    memReq = state == MEM;
    busy = state != IDLE;
    flagUpdate = aluIssue & last & (op_q == OP_CMP);
    stallF = accept | (busy & ~(last & advance));
    stallD = stallF;
    laneEn = (busy & ~flushE) ? mask : '0;
    groupIdx = grp;
    state_n = state;
    op_n = op_q;
    len_n = len_q;
    grp_n = grp;
    done_n = 1'b0;
    if (accept) begin
      state_n = is_mem(opcodeD) ? MEM : ALU;
      op_n = opcodeD;
      len_n = eff_len;
      grp_n = '0;
    end else if (busy && flushE) begin
      state_n = IDLE;
      grp_n = '0;
    end else if (advance) begin
      state_n = last ? IDLE : state;
      grp_n = last ? '0 : grp + GW'(1);
      done_n = last;
    end
  end
endmodule

// File: tb/tb_vec_seq_ctrl.sv
// tb_vec_seq_ctrl: directed and random stimulus against a transaction-level model of the sequencer
module tb_vec_seq_ctrl;
  localparam int LANES = 4;
  localparam int VLEN_MAX = 16;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic issue_valid = 1'b0, flush = 1'b0, mem_ready = 1'b0;
  logic [3:0] opcode = '0;
  logic [4:0] vec_len = '0;
  logic stall_f, stall_d, alu_issue, mem_req, flag_update, busy, done;
  logic [LANES-1:0] lane_en;
  logic [1:0] group_idx;
  int n_cmp = 0, n_bad = 0;
  bit m_busy, m_mem, m_done;
  int m_op, m_len, m_g;

  vec_seq_ctrl #(.LANES(LANES), .VLEN_MAX(VLEN_MAX)) dut (
    .clk(clk), .reset(reset), .issueValid(issue_valid), .opcodeD(opcode), .vecLen(vec_len),
    .flushE(flush), .memReady(mem_ready), .stallF(stall_f), .stallD(stall_d), .laneEn(lane_en),
    .groupIdx(group_idx), .aluIssue(alu_issue), .memReq(mem_req), .flagUpdate(flag_update),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
    end
  endtask

  task automatic step(input bit iv, input int op, input int len, input bit fl, input bit mr, input bit rs);
    int eff, groups, n, mask;
    bit vec, acc, last, e_alu, e_mem, e_stall;
    @(negedge clk);
    issue_valid = iv; opcode = 4'(op); vec_len = 5'(len); flush = fl; mem_ready = mr; reset = rs;
    if (rs) begin
      m_busy = 0; m_mem = 0; m_done = 0; m_op = 0; m_len = 0; m_g = 0;
    end
    #1;
    eff = len > VLEN_MAX ? VLEN_MAX : len;
    vec = op < 8 || op == 10 || op == 11;
    acc = !rs && !m_busy && iv && vec && eff != 0 && !fl;
    groups = (m_len + LANES - 1) / LANES;
    last = m_busy && m_g == groups - 1;
    e_alu = m_busy && !m_mem;
    e_mem = m_busy && m_mem;
    n = m_len - m_g * LANES;
    if (n > LANES) n = LANES;
    mask = (m_busy && !fl) ? (1 << n) - 1 : 0;
    e_stall = acc || (m_busy && !(last && (!m_mem || mr)));
    check("stallF", stall_f, e_stall);
    check("stallD", stall_d, e_stall);
    check("laneEn", lane_en, mask);
    check("groupIdx", group_idx, m_g);
    check("aluIssue", alu_issue, e_alu);
    check("memReq", mem_req, e_mem);
    check("flagUpdate", flag_update, e_alu && last && m_op == 7);
    check("busy", busy, m_busy);
    check("done", done, m_done);
    @(posedge clk);
    if (!rs) begin
      m_done = 0;
      if (acc) begin
        m_busy = 1; m_mem = op >= 10; m_op = op; m_len = eff; m_g = 0;
      end else if (m_busy && fl) begin
        m_busy = 0; m_g = 0;
      end else if (m_busy && (!m_mem || mr)) begin
        if (last) begin m_busy = 0; m_g = 0; m_done = 1; end
        else m_g++;
      end
    end
  endtask

  task automatic idle(input int cycles, input bit mr);
    for (int i = 0; i < cycles; i++) step(0, 0, 0, 0, mr, 0);
  endtask

  initial begin
    m_busy = 0; m_mem = 0; m_done = 0; m_op = 0; m_len = 0; m_g = 0;
    step(1, 0, 16, 0, 0, 1);
    step(1, 0, 16, 0, 0, 0);
    idle(5, 0);
    step(1, 7, 6, 0, 0, 0);
    idle(3, 0);
    step(1, 10, 8, 0, 0, 0);
    idle(3, 0);
    idle(3, 1);
    step(1, 1, 16, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    idle(2, 0);
    step(1, 2, 0, 0, 0, 0);
    step(1, 3, 20, 0, 0, 0);
    idle(5, 0);
    step(1, 8, 16, 0, 0, 0);
    step(1, 4, 9, 1, 0, 0);
    idle(1, 0);
    step(1, 11, 13, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 1);
    step(1, 11, 5, 0, 1, 0);
    idle(4, 1);
    for (int k = 0; k < 3000; k++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 15), $urandom_range(0, 20),
           $urandom_range(0, 11) == 0, $urandom_range(0, 1), $urandom_range(0, 199) == 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
